uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NREQ byte sources,
// with start strobe, busy tracking, busy-acknowledge timeout and inter-frame gap.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int DW           = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [2:0]         grant_id,
  output logic               active,
  output logic               err_timeout
);
  localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    last, winner, idx;
  logic          found, grant, start_n, timeout;
  // Scan from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = 3'((int'(last) + i) % NREQ);
      if (!found && |(req & (NREQ'(1) << idx))) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = 1'b0;
    start_n = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        grant   = found && !tx_busy;
        state_n = grant ? START : IDLE;
      end
      START: begin
        start_n = 1'b1;
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        timeout = !tx_busy && (cnt == CW'(BUSY_TIMEOUT - 1));
        cnt_n   = cnt + 1'b1;
        state_n = tx_busy ? WAIT_DONE : (timeout ? IDLE : WAIT_BUSY);
      end
      WAIT_DONE: begin
        cnt_n   = '0;
        state_n = tx_busy ? WAIT_DONE : ((GAP_CYCLES == 0) ? IDLE : GAP);
      end
      GAP: begin
        cnt_n   = cnt + 1'b1;
        state_n = (cnt == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 3'(NREQ - 1);
      ack         <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tx_start    <= start_n;
      active      <= state_n != IDLE;
      ack         <= grant ? NREQ'(1) << winner : '0;
      err_timeout <= err_timeout | timeout;
      if (grant) begin
        last     <= winner;
        grant_id <= winner;
        tx_data  <= DW'(req_data >> (int'(winner) * DW));
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus corner-case sequences; a small UART engine model
// answers tx_start with a busy pulse and a scoreboard checks every transmitted byte.
module tb_uart_tx_arbiter;
  localparam int NREQ = 2, DW = 8, BT = 16, GAP = 4, BUSY_LEN = 10;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, ack;
  logic [15:0]     req_data = '0;
  logic [DW-1:0]   tx_data;
  logic            tx_start, tx_busy, active, err_timeout;
  logic [2:0]      grant_id;
  logic            eng_busy = 1'b0, hold_busy = 1'b0, eng_en = 1'b1;
  int              tests = 0, fails = 0, cyc = 0, busy_left = 0, busy_fall_cyc = 0;
  int              starts = 0, pushed = 0, n;
  logic [7:0]      exp_q[$];
  typedef struct {
    logic [1:0] req;
    logic [7:0] d0, d1;
    logic [1:0] ack;
    logic [2:0] gid;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[8];
  assign tx_busy = eng_busy | hold_busy;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
    .err_timeout(err_timeout)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // One clock plus the engine model and the scoreboard, sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        eng_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    if (tx_start) begin
      starts++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra_start: tx_data=%0h with no byte expected", tx_data);
      end else chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      if (eng_en) begin
        eng_busy  = 1'b1;
        busy_left = BUSY_LEN;
      end
    end
  endtask
  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
    pushed++;
  endtask
  task automatic wait_idle();
    n = 0;
    while (active && n < 200) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(active), 0);
    chk("gap_after_busy", 32'(cyc - busy_fall_cyc), GAP + 1);
  endtask
  task automatic run_vec(input vec_t v);
    req = v.req;
    req_data = {v.d1, v.d0};
    push(v.data);
    tick();
    chk("ack", 32'(ack), 32'(v.ack));
    chk("grant_id", 32'(grant_id), 32'(v.gid));
    chk("tx_data", 32'(tx_data), 32'(v.data));
    chk("active_on_grant", 32'(active), 1);
    chk("no_early_start", 32'(tx_start), 0);
    req = '0;
    tick();
    chk("start_latency", 32'(tx_start), 1);
    chk("ack_one_cycle", 32'(ack), 0);
    wait_idle();
  endtask
  initial begin
    vecs[0] = '{2'b01, 8'h41, 8'h00, 2'b01, 3'd0, 8'h41};
    vecs[1] = '{2'b11, 8'h30, 8'h31, 2'b10, 3'd1, 8'h31};
    vecs[2] = '{2'b11, 8'h30, 8'h31, 2'b01, 3'd0, 8'h30};
    vecs[3] = '{2'b10, 8'h55, 8'hAA, 2'b10, 3'd1, 8'hAA};
    vecs[4] = '{2'b10, 8'h5A, 8'hC3, 2'b10, 3'd1, 8'hC3};
    vecs[5] = '{2'b11, 8'h5A, 8'hC3, 2'b01, 3'd0, 8'h5A};
    vecs[6] = '{2'b01, 8'h12, 8'h34, 2'b01, 3'd0, 8'h12};
    vecs[7] = '{2'b11, 8'h12, 8'h34, 2'b10, 3'd1, 8'h34};
    tick();
    tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    // Continuous contention: requests held high, grants must alternate.
    req = 2'b11;
    req_data = {8'h31, 8'h30};
    for (int g = 0; g < 4; g++) push((g % 2) ? 8'h31 : 8'h30);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (ack == '0 && n < 200);
      chk("cont_ack", 32'(ack), (g % 2) ? 2 : 1);
      chk("cont_grant", 32'(grant_id), g % 2);
      if (g == 3) req = '0;
    end
    wait_idle();
    // Engine never raises busy.
    eng_en = 1'b0;
    req = 2'b01;
    req_data = 16'h0077;
    push(8'h77);
    tick();
    chk("to_ack", 32'(ack), 1);
    req = '0;
    tick();
    chk("to_start", 32'(tx_start), 1);
    n = 0;
    while (!err_timeout && n < 50) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), BT);
    chk("to_idle", 32'(active), 0);
    eng_en = 1'b1;
    run_vec('{2'b10, 8'h00, 8'h99, 2'b10, 3'd1, 8'h99});
    chk("err_sticky", 32'(err_timeout), 1);
    // Busy while idle blocks arbitration.
    hold_busy = 1'b1;
    req = 2'b01;
    req_data = 16'h005C;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_idle_noack", 32'(ack), 0);
    end
    chk("busy_idle_inactive", 32'(active), 0);
    hold_busy = 1'b0;
    run_vec('{2'b01, 8'h5C, 8'h00, 2'b01, 3'd0, 8'h5C});
    // Asynchronous reset in the middle of a frame.
    req = 2'b10;
    req_data = 16'hE700;
    push(8'hE7);
    tick();
    chk("mr_ack", 32'(ack), 2);
    req = '0;
    tick();
    tick();
    tick();
    chk("mr_active_before", 32'(active), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ack0", 32'(ack), 0);
    chk("mr_tx_data0", 32'(tx_data), 0);
    chk("mr_tx_start0", 32'(tx_start), 0);
    chk("mr_grant0", 32'(grant_id), 0);
    chk("mr_active0", 32'(active), 0);
    chk("mr_err0", 32'(err_timeout), 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (eng_busy && n < 50) begin
      tick();
      n++;
    end
    run_vec('{2'b11, 8'hA1, 8'hB2, 2'b01, 3'd0, 8'hA1});
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("start_count", 32'(starts), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
